// File: rtl/axi_err_slave_pkg.sv
// Shared AXI definitions for the error slave and its helpers.
//   - AXI response codes (OKAY / SLVERR / DECERR)
//   - Write-channel FSM state encoding
package axi_err_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

endpackage

// File: rtl/axi_err_slave_req_fifo.sv
// axi_req_fifo: small synchronous FIFO holding pending read requests.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_push, i_din   write side; a push while full is ignored
//   i_pop, o_dout   read side; o_dout is the current head (valid when !o_empty)
//   o_full, o_empty occupancy flags, both derived from registered pointers
module axi_req_fifo
  import axi_err_slave_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples its inputs at the same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/axi_err_slave.sv
// axi_err_slave: AXI default slave that answers every request with an error.
// Read path: AR requests are queued; the queue head is answered with
// arlen+1 beats of zero data carrying ERR_RESP, and popped on its last beat.
// Write path: a 3-state FSM accepts AW, swallows W beats until wlast, then
// returns one B response carrying ERR_RESP.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ar*/r*                        read address / read data channels
//   aw*/w*/b*                     write address / data / response channels
//   rd_err_cnt, wr_err_cnt        saturating counts of accepted AR / AW
module axi_err_slave
  import axi_err_slave_pkg::*;
#(
  parameter int         ID_W     = 8,
  parameter int         ADDR_W   = 32,
  parameter int         DATA_W   = 32,
  parameter int         LEN_W    = 4,
  parameter int         QDEPTH   = 4,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] ERR_RESP = RESP_DECERR
) (
  input  logic              clk,
  input  logic              rst,
  // read address
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic              arvalid,
  output logic              arready,
  // read data
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  // write data
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // statistics
  output logic [CNT_W-1:0]  rd_err_cnt,
  output logic [CNT_W-1:0]  wr_err_cnt
);

  localparam int FW = ID_W + LEN_W;

  // ---------------------------------------------------------------- read path
  logic [FW-1:0]    w_head;
  logic [ID_W-1:0]  w_head_id;
  logic [LEN_W-1:0] w_head_len;
  logic             w_full;
  logic             w_empty;
  logic             w_ar_hs;
  logic             w_r_hs;
  logic             w_last_beat;
  logic [LEN_W-1:0] r_beat;
  logic [CNT_W-1:0] r_rd_cnt;

  assign w_ar_hs = arvalid && !w_full;
  // The burst in service stays at the queue head until its final beat is
  // accepted, so rid/rlast are naturally stable across rready stalls.
  assign w_r_hs      = !w_empty && rready;
  assign w_last_beat = (r_beat == w_head_len);

  axi_req_fifo #(
    .WIDTH (FW),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (arvalid),
    .i_din   ({arid, arlen}),
    .i_pop   (w_r_hs && w_last_beat),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_id, w_head_len} = w_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat   <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_r_hs) begin
        r_beat <= w_last_beat ? '0 : r_beat + LEN_W'(1);
      end
      if (w_ar_hs && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
    end
  end

  assign arready    = !w_full;
  assign rvalid     = !w_empty;
  assign rid        = w_empty ? '0 : w_head_id;
  assign rdata      = '0;
  assign rresp      = w_empty ? RESP_OKAY : ERR_RESP;
  assign rlast      = !w_empty && w_last_beat;
  assign rd_err_cnt = r_rd_cnt;

  // --------------------------------------------------------------- write path
  w_state_e         r_w_state;
  logic             r_awready;
  logic             r_wready;
  logic             r_bvalid;
  logic [ID_W-1:0]  r_awid;
  logic [ID_W-1:0]  r_bid;
  logic [1:0]       r_bresp;
  logic [CNT_W-1:0] r_wr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_awid    <= '0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_wr_cnt  <= '0;
    end else begin
      case (r_w_state)
        W_IDLE: begin
          if (awvalid) begin
            r_w_state <= W_DATA;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_awid    <= awid;
            if (r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
          end
        end
        W_DATA: begin
          // Only wlast ends the burst; beat count is not tracked.
          if (wvalid && wlast) begin
            r_w_state <= W_RESP;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bid     <= r_awid;
            r_bresp   <= ERR_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_w_state <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
          end
        end
        default: begin
          r_w_state <= W_IDLE;
          r_awready <= 1'b1;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
          r_bid     <= '0;
          r_bresp   <= RESP_OKAY;
        end
      endcase
    end
  end

  assign awready    = r_awready;
  assign wready     = r_wready;
  assign bvalid     = r_bvalid;
  assign bid        = r_bid;
  assign bresp      = r_bresp;
  assign wr_err_cnt = r_wr_cnt;

  // Addresses are accepted but never decoded.
  logic w_unused_addr;
  assign w_unused_addr = ^{araddr, awaddr};

endmodule

// File: tb/tb_axi_err_slave.sv
// Self-checking bench for axi_err_slave: a table of write-channel vectors
// plus hand-written read/concurrency/reset sequences. CNT_W=2 throughout so
// counter saturation is reachable.
module tb_axi_err_slave;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int QDEPTH = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ID_W-1:0]   arid = '0;
  logic [ADDR_W-1:0] araddr = '0;
  logic [LEN_W-1:0]  arlen = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [ID_W-1:0]   awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic [CNT_W-1:0]  rd_err_cnt;
  logic [CNT_W-1:0]  wr_err_cnt;

  axi_err_slave #(
    .ID_W     (ID_W),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .QDEPTH   (QDEPTH),
    .CNT_W    (CNT_W),
    .ERR_RESP (2'b11)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arid       (arid),
    .araddr     (araddr),
    .arlen      (arlen),
    .arvalid    (arvalid),
    .arready    (arready),
    .rid        (rid),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .rvalid     (rvalid),
    .rready     (rready),
    .awid       (awid),
    .awaddr     (awaddr),
    .awvalid    (awvalid),
    .awready    (awready),
    .wlast      (wlast),
    .wvalid     (wvalid),
    .wready     (wready),
    .bid        (bid),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .rd_err_cnt (rd_err_cnt),
    .wr_err_cnt (wr_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic            awvalid;
    logic [ID_W-1:0] awid;
    logic            wvalid;
    logic            wlast;
    logic            bready;
    logic            e_awready;
    logic            e_wready;
    logic            e_bvalid;
    logic [ID_W-1:0] e_bid;
    logic [1:0]      e_bresp;
    logic [1:0]      e_cnt;
  } wvec_t;

  localparam int NV = 19;
  wvec_t wv [NV];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    rready = 1'b0; bready = 1'b0;
    #1;
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_rd_cnt", rd_err_cnt, 0);
    check("rst_wr_cnt", wr_err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rel_arready", arready, 1);
    check("rel_awready", awready, 1);
    check("rel_rvalid", rvalid, 0);
  endtask

  task automatic ar_push(input logic [ID_W-1:0] id, input logic [LEN_W-1:0] len);
    @(negedge clk);
    arvalid = 1'b1;
    arid    = id;
    arlen   = len;
    araddr  = $urandom;
    #1;
    check("push_arready", arready, 1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int xfers;
    // awvalid awid wvalid wlast bready | awready wready bvalid bid bresp cnt
    wv[0]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0};
    wv[1]  = '{1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd0};
    wv[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'd1};
    wv[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'd1};
    wv[4]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 2'b11, 2'd1};
    wv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h09, 2'b11, 2'd1};
    wv[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd1};
    wv[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'd2};
    wv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 2'b11, 2'd2};
    wv[9]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd2};
    wv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'd3};
    wv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 2'b11, 2'd3};
    wv[12] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd3};
    wv[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'd3};
    wv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 2'b11, 2'd3};
    wv[15] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd3};
    wv[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 2'd3};
    wv[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 2'b11, 2'd3};
    wv[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 2'd3};

    // ---- write FSM vectors, including counter saturation (1,2,3,3,3)
    do_reset();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      awvalid = wv[i].awvalid;
      awid    = wv[i].awid;
      wvalid  = wv[i].wvalid;
      wlast   = wv[i].wlast;
      bready  = wv[i].bready;
      #1;
      check($sformatf("wv%0d_awready", i), awready, wv[i].e_awready);
      check($sformatf("wv%0d_wready", i), wready, wv[i].e_wready);
      check($sformatf("wv%0d_bvalid", i), bvalid, wv[i].e_bvalid);
      check($sformatf("wv%0d_bid", i), bid, wv[i].e_bid);
      check($sformatf("wv%0d_bresp", i), bresp, wv[i].e_bresp);
      check($sformatf("wv%0d_wr_cnt", i), wr_err_cnt, wv[i].e_cnt);
      check($sformatf("wv%0d_rvalid", i), rvalid, 0);
    end
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;

    // ---- single burst id=5 len=3
    do_reset();
    rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b1; arid = 8'd5; arlen = 4'd3;
    #1;
    check("b1_no_early_rvalid", rvalid, 0);
    check("b1_arready", arready, 1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      #1;
      check($sformatf("b1_rvalid%0d", b), rvalid, 1);
      check($sformatf("b1_rid%0d", b), rid, 5);
      check($sformatf("b1_rdata%0d", b), rdata, 0);
      check($sformatf("b1_rresp%0d", b), rresp, 3);
      check($sformatf("b1_rlast%0d", b), rlast, (b == 3));
    end
    @(negedge clk);
    #1;
    check("b1_idle_rvalid", rvalid, 0);
    check("b1_idle_rid", rid, 0);
    check("b1_idle_rresp", rresp, 0);
    check("b1_idle_rlast", rlast, 0);
    check("b1_rd_cnt", rd_err_cnt, 1);

    // ---- queue full: four ARs fill it, fifth waits until a pop
    do_reset();
    for (int k = 1; k <= 4; k++) ar_push(8'(k), 4'd0);
    @(negedge clk);
    arvalid = 1'b1; arid = 8'd5; arlen = 4'd0;
    #1;
    check("q_full_arready", arready, 0);
    check("q_head_rvalid", rvalid, 1);
    check("q_head_rid", rid, 1);
    check("q_head_rlast", rlast, 1);
    @(negedge clk);
    #1;
    check("q_hold_arready", arready, 0);
    check("q_hold_rid", rid, 1);
    @(negedge clk);
    rready = 1'b1;
    #1;
    check("q_a_arready", arready, 0);
    check("q_a_rid", rid, 1);
    @(negedge clk);
    #1;
    check("q_b_arready", arready, 1);
    check("q_b_rid", rid, 2);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    check("q_c_rid", rid, 3);
    check("q_c_arready", arready, 1);
    @(negedge clk);
    #1;
    check("q_d_rid", rid, 4);
    @(negedge clk);
    #1;
    check("q_e_rid", rid, 5);
    check("q_e_rlast", rlast, 1);
    @(negedge clk);
    #1;
    check("q_f_rvalid", rvalid, 0);
    check("q_f_rd_cnt_sat", rd_err_cnt, 3);

    // ---- rready toggled every cycle during a len=2 burst
    do_reset();
    ar_push(8'd7, 4'd2);
    xfers = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rready = (c % 2 == 0);
      #1;
      check($sformatf("t_rvalid%0d", c), rvalid, (xfers < 3));
      if (xfers < 3) begin
        check($sformatf("t_rid%0d", c), rid, 7);
        check($sformatf("t_rlast%0d", c), rlast, (xfers == 2));
        check($sformatf("t_rresp%0d", c), rresp, 3);
      end
      if (rvalid && rready) xfers++;
    end
    check("t_beats", xfers, 3);
    rready = 1'b0;

    // ---- concurrent read burst len=7 and a 2-beat write
    do_reset();
    rready = 1'b1;
    @(negedge clk);
    arvalid = 1'b1; arid = 8'h21; arlen = 4'd7;
    awvalid = 1'b1; awid = 8'd9;
    #1;
    check("c_arready", arready, 1);
    check("c_awready", awready, 1);
    @(posedge clk);
    #1;
    arvalid = 1'b0; awvalid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wvalid = (c < 2);
      wlast  = (c == 1);
      bready = (c == 2);
      #1;
      check($sformatf("c_rvalid%0d", c), rvalid, 1);
      check($sformatf("c_rid%0d", c), rid, 8'h21);
      check($sformatf("c_rlast%0d", c), rlast, (c == 7));
      if (c < 2) check($sformatf("c_wready%0d", c), wready, 1);
      if (c == 2) begin
        check("c_bvalid", bvalid, 1);
        check("c_bid", bid, 9);
        check("c_bresp", bresp, 3);
      end
      if (c == 3) begin
        check("c_b_done", bvalid, 0);
        check("c_aw_back", awready, 1);
      end
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    @(negedge clk);
    #1;
    check("c_end_rvalid", rvalid, 0);
    check("c_rd_cnt", rd_err_cnt, 1);
    check("c_wr_cnt", wr_err_cnt, 1);

    // ---- reset during beat 2 of a len=3 burst, with a write in progress
    do_reset();
    @(negedge clk);
    awvalid = 1'b1; awid = 8'd1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    rready = 1'b1;
    ar_push(8'd4, 4'd3);
    @(negedge clk);
    #1;
    check("m_beat1_rvalid", rvalid, 1);
    check("m_beat1_rlast", rlast, 0);
    @(negedge clk);
    #1;
    check("m_beat2_rvalid", rvalid, 1);
    check("m_pre_rd_cnt", rd_err_cnt, 1);
    check("m_pre_wr_cnt", wr_err_cnt, 1);
    rst = 1'b0;
    #1;
    check("m_rst_rvalid", rvalid, 0);
    check("m_rst_rd_cnt", rd_err_cnt, 0);
    check("m_rst_wr_cnt", wr_err_cnt, 0);
    check("m_rst_wready", wready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("m_post_rvalid%0d", c), rvalid, 0);
    end
    check("m_post_arready", arready, 1);
    check("m_post_awready", awready, 1);
    check("m_post_rd_cnt", rd_err_cnt, 0);
    check("m_post_wr_cnt", wr_err_cnt, 0);
    rready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
